pixel_fetcher: RTL and testbench

Read-side engine at the far end of the controller's fetcher command channel. Accepts one 128-bit fetch command (base address, pixel length, burst size, opcode) and issues burst read requests to memory. Forwards the returned words to the downstream pixel FIFO. Raises a level `fetcher_command_complete` that the controller combines with the storer's completion to clear its status register.

---
 rtl/pixel_fetcher.sv | 134 +++++++++++++
 tb/tb_pixel_fetcher.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fetcher.sv
// Read-side fetch engine: turns one fetch command into a sequence of burst
// reads sized to fit the downstream FIFO and forwards the returned words.
module pixel_fetcher #(
    parameter int ADDRESS_SIZE = 36,
    parameter int DATA_WIDTH   = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   fetcher_command,
    input  logic                    fetcher_command_valid,
    output logic                    fetcher_command_complete,
    output logic                    fetcher_busy,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    output logic [15:0]             mem_burstcount,
    output logic                    mem_rdreq,
    input  logic                    mem_rdack,
    input  logic                    mem_rdvalid,
    input  logic [DATA_WIDTH-1:0]   mem_datain,
    input  logic [15:0]             out_space,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        REQ  = 2'd2,
        DATA = 2'd3
    } state_t;

    state_t                  state_r;
    logic [ADDRESS_SIZE-1:0] addr_r;
    logic [35:0]             remaining_r;
    logic [15:0]             burst_r;
    logic [15:0]             beat_cnt_r;

    logic [35:0] cmd_addr_s;
    logic [35:0] cmd_len_s;
    logic [15:0] cmd_burst_s;
    logic [3:0]  cmd_op_s;
    logic        accept_s;
    logic [15:0] chunk_s;
    logic        unused_cmd_s;

    assign cmd_addr_s   = fetcher_command[91:56];
    assign cmd_len_s    = fetcher_command[55:20];
    assign cmd_burst_s  = fetcher_command[19:4];
    assign cmd_op_s     = fetcher_command[3:0];
    assign unused_cmd_s = ^fetcher_command[DATA_WIDTH-1:92];

    assign accept_s     = fetcher_command_valid && (cmd_op_s == 4'b0111) && (state_r == IDLE);
    // Next burst is the configured size, trimmed to what is left of the command.
    assign chunk_s      = (remaining_r < {20'd0, burst_r}) ? remaining_r[15:0] : burst_r;
    assign fetcher_busy = (state_r != IDLE);

    // Command sequencing FSM with registered memory-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r                  <= IDLE;
            addr_r                   <= {ADDRESS_SIZE{1'b0}};
            remaining_r              <= 36'd0;
            burst_r                  <= 16'd0;
            beat_cnt_r               <= 16'd0;
            mem_address              <= {ADDRESS_SIZE{1'b0}};
            mem_burstcount           <= 16'd0;
            mem_rdreq                <= 1'b0;
            fetcher_command_complete <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_r      <= cmd_addr_s[ADDRESS_SIZE-1:0];
                        remaining_r <= cmd_len_s;
                        burst_r     <= (cmd_burst_s == 16'd0) ? 16'd1 : cmd_burst_s;
                        if (cmd_len_s == 36'd0) begin
                            fetcher_command_complete <= 1'b1;
                        end else begin
                            fetcher_command_complete <= 1'b0;
                            state_r                  <= ARB;
                        end
                    end
                end
                ARB: begin
                    if (out_space >= chunk_s) begin
                        mem_address    <= addr_r;
                        mem_burstcount <= chunk_s;
                        mem_rdreq      <= 1'b1;
                        state_r        <= REQ;
                    end
                end
                REQ: begin
                    if (mem_rdack) begin
                        mem_rdreq  <= 1'b0;
                        beat_cnt_r <= mem_burstcount;
                        state_r    <= DATA;
                    end
                end
                DATA: begin
                    if (mem_rdvalid) begin
                        beat_cnt_r  <= beat_cnt_r - 16'd1;
                        remaining_r <= remaining_r - 36'd1;
                        if (beat_cnt_r == 16'd1) begin
                            if (remaining_r == 36'd1) begin
                                fetcher_command_complete <= 1'b1;
                                state_r                  <= IDLE;
                            end else begin
                                addr_r  <= addr_r + ADDRESS_SIZE'({mem_burstcount, 4'b0000});
                                state_r <= ARB;
                            end
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_rdreq <= 1'b0;
                end
            endcase
        end
    end

    // Forward read beats one cycle later; beats outside DATA are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= {DATA_WIDTH{1'b0}};
        end else begin
            out_valid <= (state_r == DATA) && mem_rdvalid;
            if ((state_r == DATA) && mem_rdvalid) begin
                out_data <= mem_datain;
            end
        end
    end

endmodule

// File: tb/tb_pixel_fetcher.sv
// Scoreboard bench for pixel_fetcher: expected requests and beats are queued
// as stimulus is driven and compared when the DUT presents them.
module tb_pixel_fetcher;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] fetcher_command = '0;
    logic         fetcher_command_valid = 1'b0;
    logic         fetcher_command_complete;
    logic         fetcher_busy;
    logic [35:0]  mem_address;
    logic [15:0]  mem_burstcount;
    logic         mem_rdreq;
    logic         mem_rdack = 1'b0;
    logic         mem_rdvalid = 1'b0;
    logic [127:0] mem_datain = '0;
    logic [15:0]  out_space = 16'd16;
    logic [127:0] out_data;
    logic         out_valid;

    int checks = 0;
    int failures = 0;
    int beats_pushed = 0;
    int beats_seen = 0;

    logic [35:0]  req_addr_q[$];
    logic [15:0]  req_cnt_q[$];
    logic [127:0] data_q[$];

    pixel_fetcher #(.ADDRESS_SIZE(36), .DATA_WIDTH(128)) dut (
        .clk(clk), .rst(rst),
        .fetcher_command(fetcher_command),
        .fetcher_command_valid(fetcher_command_valid),
        .fetcher_command_complete(fetcher_command_complete),
        .fetcher_busy(fetcher_busy),
        .mem_address(mem_address),
        .mem_burstcount(mem_burstcount),
        .mem_rdreq(mem_rdreq),
        .mem_rdack(mem_rdack),
        .mem_rdvalid(mem_rdvalid),
        .mem_datain(mem_datain),
        .out_space(out_space),
        .out_data(out_data),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [35:0] a, input logic [35:0] l,
                            input logic [15:0] b, input logic [3:0] op);
        fetcher_command       = {36'd0, a, l, b, op};
        fetcher_command_valid = 1'b1;
        tick();
        fetcher_command_valid = 1'b0;
    endtask

    task automatic expect_req(input logic [35:0] a, input logic [15:0] n);
        req_addr_q.push_back(a);
        req_cnt_q.push_back(n);
    endtask

    // Wait (bounded) for a request and compare it against the next queued one.
    task automatic take_req(output logic [15:0] cnt, output bit ok);
        int w;
        w = 0;
        ok = 1'b0;
        cnt = 16'd0;
        while (mem_rdreq !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        check_eq("req_wait", mem_rdreq, 1'b1);
        if (mem_rdreq !== 1'b1) return;
        if (req_addr_q.size() == 0) begin
            check_eq("req_unexpected", 1'b1, 1'b0);
            return;
        end
        check_eq("req_addr", mem_address, req_addr_q.pop_front());
        cnt = req_cnt_q.pop_front();
        check_eq("req_count", mem_burstcount, cnt);
        ok = 1'b1;
    endtask

    task automatic serve(input int ack_delay);
        logic [15:0]  cnt;
        logic [35:0]  a0;
        logic [127:0] d;
        bit           ok;
        take_req(cnt, ok);
        if (!ok) return;
        a0 = mem_address;
        for (int i = 0; i < ack_delay; i++) begin
            tick();
            check_eq("hold_rdreq", mem_rdreq, 1'b1);
            check_eq("hold_addr", mem_address, a0);
            check_eq("hold_count", mem_burstcount, cnt);
        end
        mem_rdack = 1'b1;
        tick();
        mem_rdack = 1'b0;
        check_eq("rdreq_drop", mem_rdreq, 1'b0);
        for (int i = 0; i < int'(cnt); i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            mem_rdvalid = 1'b1;
            mem_datain  = d;
            data_q.push_back(d);
            beats_pushed++;
            tick();
        end
        mem_rdvalid = 1'b0;
    endtask

    // Output monitor: every forwarded beat must match the next expected word.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            beats_seen++;
            if (data_q.size() == 0) check_eq("beat_unexpected", 1'b1, 1'b0);
            else check_eq("out_data", out_data, data_q.pop_front());
        end
    end

    initial begin
        logic [15:0] cnt;
        bit          ok;

        // Asynchronous reset mid-cycle
        #12;
        rst = 1'b1;
        #1;
        check_eq("rst_complete", fetcher_command_complete, 1'b0);
        check_eq("rst_busy", fetcher_busy, 1'b0);
        check_eq("rst_rdreq", mem_rdreq, 1'b0);
        check_eq("rst_addr", mem_address, 36'd0);
        check_eq("rst_count", mem_burstcount, 16'd0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_data", out_data, 128'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_hold_rdreq", mem_rdreq, 1'b0);
        end
        rst = 1'b0;
        tick();

        // Basic fetch: two full bursts
        expect_req(36'h0_0000_1000, 16'd4);
        expect_req(36'h0_0000_1040, 16'd4);
        send_cmd(36'h0_0000_1000, 36'd8, 16'd4, 4'b0111);
        check_eq("basic_busy_k1", fetcher_busy, 1'b1);
        check_eq("basic_rdreq_k1", mem_rdreq, 1'b0);
        tick();
        check_eq("basic_rdreq_k2", mem_rdreq, 1'b1);
        serve(0);
        serve(0);
        check_eq("basic_complete", fetcher_command_complete, 1'b1);
        check_eq("basic_busy_done", fetcher_busy, 1'b0);
        tick();

        // Partial last burst
        expect_req(36'h0_0000_2000, 16'd4);
        expect_req(36'h0_0000_2040, 16'd1);
        send_cmd(36'h0_0000_2000, 36'd5, 16'd4, 4'b0111);
        check_eq("partial_complete_clear", fetcher_command_complete, 1'b0);
        serve(0);
        check_eq("partial_mid_complete", fetcher_command_complete, 1'b0);
        serve(0);
        check_eq("partial_complete", fetcher_command_complete, 1'b1);
        check_eq("partial_busy", fetcher_busy, 1'b0);

        // Zero-length command completes without ever going busy
        send_cmd(36'h0_0000_5000, 36'd0, 16'd4, 4'b0111);
        check_eq("zero_complete", fetcher_command_complete, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_eq("zero_busy", fetcher_busy, 1'b0);
            check_eq("zero_rdreq", mem_rdreq, 1'b0);
            tick();
        end

        // Wrong opcode is ignored, complete stays set
        send_cmd(36'h0_0000_6000, 36'd4, 16'd4, 4'b0011);
        for (int i = 0; i < 3; i++) begin
            check_eq("filter_complete", fetcher_command_complete, 1'b1);
            check_eq("filter_busy", fetcher_busy, 1'b0);
            check_eq("filter_rdreq", mem_rdreq, 1'b0);
            tick();
        end

        // Command while busy is ignored; B=0 acts as B=1
        expect_req(36'h0_0000_3000, 16'd1);
        expect_req(36'h0_0000_3010, 16'd1);
        send_cmd(36'h0_0000_3000, 36'd2, 16'd0, 4'b0111);
        send_cmd(36'h0_0000_9000, 36'd4, 16'd4, 4'b0111);
        serve(0);
        serve(0);
        check_eq("busycmd_complete", fetcher_command_complete, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("busycmd_idle", fetcher_busy, 1'b0);
            check_eq("busycmd_rdreq", mem_rdreq, 1'b0);
        end

        // Backpressure from out_space, then a slow acknowledge
        out_space = 16'd2;
        expect_req(36'h0_0000_4000, 16'd4);
        send_cmd(36'h0_0000_4000, 36'd4, 16'd4, 4'b0111);
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_busy", fetcher_busy, 1'b1);
            check_eq("bp_rdreq", mem_rdreq, 1'b0);
            tick();
        end
        out_space = 16'd4;
        tick();
        tick();
        check_eq("bp_rdreq_after_space", mem_rdreq, 1'b1);
        serve(5);
        check_eq("bp_complete", fetcher_command_complete, 1'b1);
        out_space = 16'd16;
        tick();

        // Address wrap, then reset in the middle of the command
        expect_req(36'hF_FFFF_FFF0, 16'd1);
        expect_req(36'h0_0000_0000, 16'd1);
        send_cmd(36'hF_FFFF_FFF0, 36'd2, 16'd1, 4'b0111);
        serve(0);
        check_eq("wrap_mid_busy", fetcher_busy, 1'b1);
        take_req(cnt, ok);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", fetcher_busy, 1'b0);
        check_eq("midrst_complete", fetcher_command_complete, 1'b0);
        check_eq("midrst_rdreq", mem_rdreq, 1'b0);
        tick();
        rst = 1'b0;
        mem_rdvalid = 1'b1;
        mem_datain  = 128'hDEAD_BEEF;
        tick();
        mem_rdvalid = 1'b0;
        tick();
        check_eq("midrst_no_forward", out_valid, 1'b0);
        check_eq("midrst_idle", fetcher_busy, 1'b0);
        check_eq("midrst_no_req", mem_rdreq, 1'b0);
        tick();

        check_eq("beats_all_seen", beats_seen, beats_pushed);
        check_eq("data_q_empty", data_q.size(), 0);
        check_eq("req_q_empty", req_addr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

endmodule
